// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell reused LSB-first over WIDTH cycles; SERIAL_ADD_OVF_EN adds a signed-overflow flag.
// Latency: start accepted at edge k, done pulses in cycle k+WIDTH+1; busy spans RUN and DONE.
// Backpressure: start is honoured only in IDLE; requests while busy are dropped, never queued.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
        $error("serial_add_ctrl: need WIDTH >= 2 and 2**CNT_W > WIDTH");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (c_reg),
        .s  (fa_s),
        .co (fa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // sum/cout only move on the final RUN edge, so the previous result stays visible while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            acc   <= '0;
            c_reg <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= {fa_s, acc[WIDTH-1:1]};
            c_reg <= fa_c;
            if (last) begin
                sum_q  <= {fa_s, acc[WIDTH-1:1]};
                cout_q <= fa_c;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // Carry into the MSB is c_reg on the last step; carry out is fa_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= c_reg ^ fa_c;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// One-bit combinational full adder shared by the serial sequencer.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule
